// File: rtl/pipe_stage_reg_if.sv
// Bundle of control, input and output fields for one pipeline boundary register.
// The master drives the incoming instruction and controls; the slave is the register itself.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int TNEW_W = 3,
    parameter int REG_W  = 5
);
    logic              flush;
    logic              hold;
    logic              stall;
    logic              in_valid;
    logic [31:0]       in_ins;
    logic [31:0]       in_pc;
    logic [DATA_W-1:0] in_imm;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [REG_W-1:0]  in_rs;
    logic [REG_W-1:0]  in_rt;
    logic [REG_W-1:0]  in_rd;
    logic [TNEW_W-1:0] in_tnew;

    logic              out_valid;
    logic [31:0]       out_ins;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [REG_W-1:0]  out_rs;
    logic [REG_W-1:0]  out_rt;
    logic [REG_W-1:0]  out_rd;
    logic [TNEW_W-1:0] out_tnew;

    modport master (
        output flush, hold, stall, in_valid, in_ins, in_pc, in_imm, in_a, in_b,
               in_rs, in_rt, in_rd, in_tnew,
        input  out_valid, out_ins, out_pc, out_imm, out_a, out_b,
               out_rs, out_rt, out_rd, out_tnew
    );

    modport slave (
        input  flush, hold, stall, in_valid, in_ins, in_pc, in_imm, in_a, in_b,
               in_rs, in_rt, in_rd, in_tnew,
        output out_valid, out_ins, out_pc, out_imm, out_a, out_b,
               out_rs, out_rt, out_rd, out_tnew
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Configurable inter-stage pipeline register: load / hold / bubble / flush with fixed priority.
// Define PIPE_REG_PERF_EN to add saturating bubble_cnt and hold_cnt performance counters.
module pipe_stage_reg #(
    parameter int          DATA_W   = 32,
    parameter int          TNEW_W   = 3,
    parameter int          REG_W    = 5,
    parameter int          TNEW_DEC = 1,
    parameter logic [31:0] PC_RST   = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
`ifdef PIPE_REG_PERF_EN
    output logic [15:0] bubble_cnt,
    output logic [15:0] hold_cnt,
`endif
    pipe_stage_reg_if.slave bus
);
    localparam logic [TNEW_W-1:0] DEC = TNEW_W'(TNEW_DEC);

    logic              valid_q, valid_d;
    logic [31:0]       ins_q, ins_d;
    logic [31:0]       pc_q, pc_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [REG_W-1:0]  rs_q, rs_d;
    logic [REG_W-1:0]  rt_q, rt_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [TNEW_W-1:0] tnew_q, tnew_d;

    always_comb begin
        valid_d = valid_q;
        ins_d   = ins_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        a_d     = a_q;
        b_d     = b_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        tnew_d  = tnew_q;
        if (!bus.hold || bus.flush) begin
            // Any non-hold action replaces the contents; a bubble keeps only the PC.
            valid_d = 1'b0;
            ins_d   = '0;
            pc_d    = bus.in_pc;
            imm_d   = '0;
            a_d     = '0;
            b_d     = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            tnew_d  = '0;
            if (!bus.flush && !bus.stall && bus.in_valid) begin
                valid_d = 1'b1;
                ins_d   = bus.in_ins;
                imm_d   = bus.in_imm;
                a_d     = bus.in_a;
                b_d     = bus.in_b;
                rs_d    = bus.in_rs;
                rt_d    = bus.in_rt;
                rd_d    = bus.in_rd;
                // A write to $0 never creates a hazard, so its countdown is dropped.
                if (bus.in_rd != '0 && bus.in_tnew > DEC) begin
                    tnew_d = bus.in_tnew - DEC;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ins_q   <= '0;
            pc_q    <= PC_RST;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            tnew_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ins_q   <= ins_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            tnew_q  <= tnew_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_ins   = ins_q;
    assign bus.out_pc    = pc_q;
    assign bus.out_imm   = imm_q;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_rs    = rs_q;
    assign bus.out_rt    = rt_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_tnew  = tnew_q;

`ifdef PIPE_REG_PERF_EN
    logic        bubble_ev, hold_ev;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;

    // Flush beats hold; hold beats stall; an invalid load is also a bubble.
    assign bubble_ev = bus.flush | (~bus.hold & (bus.stall | ~bus.in_valid));
    assign hold_ev   = ~bus.flush & bus.hold;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        if (bubble_ev && bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
        if (hold_ev && hold_cnt_q != 16'hFFFF)     hold_cnt_d   = hold_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign hold_cnt   = hold_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks of pipe_stage_reg against a rule-level reference model.
// Counter checks are compiled in when PIPE_REG_PERF_EN is defined.
module tb_pipe_stage_reg;
    localparam int          DATA_W   = 32;
    localparam int          TNEW_W   = 3;
    localparam int          REG_W    = 5;
    localparam int          TNEW_DEC = 1;
    localparam logic [31:0] PC_RST   = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .TNEW_W(TNEW_W), .REG_W(REG_W)) bus ();

`ifdef PIPE_REG_PERF_EN
    logic [15:0] bubble_cnt, hold_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W(DATA_W), .TNEW_W(TNEW_W), .REG_W(REG_W),
        .TNEW_DEC(TNEW_DEC), .PC_RST(PC_RST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef PIPE_REG_PERF_EN
        .bubble_cnt (bubble_cnt),
        .hold_cnt   (hold_cnt),
`endif
        .bus        (bus)
    );

    typedef struct {
        logic        valid;
        logic [31:0] ins, pc, imm, a, b;
        int          rs, rt, rd, tnew;
    } st_t;

    st_t m;
    int  m_bub, m_hold;

    function automatic st_t bubble_of(input logic [31:0] pc);
        st_t s;
        s = '{valid: 1'b0, ins: 32'h0, pc: pc, imm: 32'h0, a: 32'h0, b: 32'h0,
              rs: 0, rt: 0, rd: 0, tnew: 0};
        return s;
    endfunction

    task automatic model_reset();
        m = bubble_of(PC_RST);
        m_bub = 0;
        m_hold = 0;
    endtask

    // Next state from the prioritised action list: flush > hold > stall > load.
    task automatic model_step();
        int t;
        if (bus.flush) begin
            m = bubble_of(bus.in_pc);
            if (m_bub < 65535) m_bub++;
        end else if (bus.hold) begin
            if (m_hold < 65535) m_hold++;
        end else if (bus.stall || !bus.in_valid) begin
            m = bubble_of(bus.in_pc);
            if (m_bub < 65535) m_bub++;
        end else begin
            t = int'(bus.in_tnew) - TNEW_DEC;
            if (t < 0) t = 0;
            if (bus.in_rd == 0) t = 0;
            m = '{valid: 1'b1, ins: bus.in_ins, pc: bus.in_pc, imm: bus.in_imm,
                  a: bus.in_a, b: bus.in_b, rs: int'(bus.in_rs), rt: int'(bus.in_rt),
                  rd: int'(bus.in_rd), tnew: t};
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, {31'b0, bus.out_valid}, {31'b0, m.valid});
        chk({tag, ".ins"},   bus.out_ins, m.ins);
        chk({tag, ".pc"},    bus.out_pc, m.pc);
        chk({tag, ".imm"},   bus.out_imm, m.imm);
        chk({tag, ".a"},     bus.out_a, m.a);
        chk({tag, ".b"},     bus.out_b, m.b);
        chk({tag, ".rs"},    32'(bus.out_rs), 32'(m.rs));
        chk({tag, ".rt"},    32'(bus.out_rt), 32'(m.rt));
        chk({tag, ".rd"},    32'(bus.out_rd), 32'(m.rd));
        chk({tag, ".tnew"},  32'(bus.out_tnew), 32'(m.tnew));
`ifdef PIPE_REG_PERF_EN
        chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(m_bub));
        chk({tag, ".hold_cnt"},   32'(hold_cnt), 32'(m_hold));
`endif
        $display("step %-10s ctl f/h/s=%b%b%b valid=%b pc=%h ins=%h tnew=%0d",
                 tag, bus.flush, bus.hold, bus.stall, bus.out_valid, bus.out_pc,
                 bus.out_ins, bus.out_tnew);
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_ctl(input logic f, input logic h, input logic s);
        bus.flush = f;
        bus.hold  = h;
        bus.stall = s;
    endtask

    task automatic randomize_payload();
        bus.in_valid = 1'b1;
        bus.in_ins   = $urandom;
        bus.in_pc    = $urandom & 32'hFFFF_FFFC;
        bus.in_imm   = $urandom;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_rs    = REG_W'($urandom_range(31, 0));
        bus.in_rt    = REG_W'($urandom_range(31, 0));
        bus.in_rd    = REG_W'($urandom_range(31, 0));
        bus.in_tnew  = TNEW_W'($urandom_range(7, 0));
    endtask

    initial begin
        set_ctl(1'b0, 1'b0, 1'b0);
        randomize_payload();
        model_reset();

        // Reset state observed with reset held low across an edge.
        @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Load with decrement.
        randomize_payload();
        bus.in_ins = 32'h8C22_0004; bus.in_pc = 32'h0000_3008;
        bus.in_rd = 5'd2; bus.in_tnew = 3'd3;
        step("load_t3");
        chk("load_t3.tnew_abs", 32'(bus.out_tnew), 32'd2);
        chk("load_t3.pc_abs", bus.out_pc, 32'h0000_3008);
        bus.in_tnew = 3'd0;
        step("load_t0");

        // $0 destination never carries a countdown.
        randomize_payload();
        bus.in_rd = 5'd0; bus.in_tnew = 3'd2;
        step("rd_zero");
        chk("rd_zero.tnew_abs", 32'(bus.out_tnew), 32'd0);

        // Stall inserts a bubble carrying in_pc.
        randomize_payload();
        bus.in_pc = 32'h0000_300C;
        set_ctl(1'b0, 1'b0, 1'b1);
        step("stall");
        chk("stall.pc_abs", bus.out_pc, 32'h0000_300C);

        // Hold for four cycles on a T_new=2 instruction (loaded with in_tnew=3).
        randomize_payload();
        bus.in_rd = 5'd7; bus.in_tnew = 3'd3;
        set_ctl(1'b0, 1'b0, 1'b0);
        step("pre_hold");
        for (int i = 0; i < 4; i++) begin
            randomize_payload();
            set_ctl(1'b0, 1'b1, 1'($urandom_range(1, 0)));
            step("hold");
        end
        chk("hold.tnew_abs", 32'(bus.out_tnew), 32'd2);
`ifdef PIPE_REG_PERF_EN
        chk("hold.cnt_abs", 32'(hold_cnt), 32'd4);
`endif

        // Priority: flush + hold + stall is one bubble; hold + stall keeps contents.
        randomize_payload();
        set_ctl(1'b0, 1'b0, 1'b0);
        step("pre_prio");
        randomize_payload();
        set_ctl(1'b1, 1'b1, 1'b1);
        step("fhs");
        randomize_payload();
        set_ctl(1'b0, 1'b0, 1'b0);
        step("reload");
        randomize_payload();
        set_ctl(1'b0, 1'b1, 1'b1);
        step("hs");

        // Random mix of controls and payloads.
        for (int i = 0; i < 300; i++) begin
            randomize_payload();
            bus.in_valid = ($urandom_range(7, 0) != 0);
            set_ctl(($urandom_range(9, 0) == 0), ($urandom_range(5, 0) == 0),
                    ($urandom_range(5, 0) == 0));
            step("rand");
        end

        // Asynchronous reset mid-cycle with the register loaded.
        randomize_payload();
        bus.in_rd = 5'd3; bus.in_tnew = 3'd5;
        set_ctl(1'b0, 1'b0, 1'b0);
        step("pre_rst");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b1;
        randomize_payload();
        step("post_rst");

`ifdef PIPE_REG_PERF_EN
        // Drive bubble_cnt to saturation, then stall further.
        set_ctl(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65540; i++) begin
            model_step();
            @(posedge clk);
        end
        #1;
        check_all("sat");
        chk("sat.cnt_abs", 32'(bubble_cnt), 32'h0000_FFFF);
        step("sat_more");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
